// File: rtl/uart_tx_ser.sv
// UART transmit stage: byte FIFO feeding an 8N1 serializer.
// TXD advances one bit per sio_ce tick; status flags back to the register block.
module uart_tx_ser #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sio_ce,
    input  logic [7:0] din_i,
    input  logic       we_i,
    input  logic       cts_i,
    input  logic       clr_ovr_i,
    output logic       txd_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       ovr_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          txd_q, txd_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    mem_q [DEPTH];

    logic full, empty, push, pop, can_start;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign push      = we_i & ~full;
    assign can_start = ~empty & ~cts_i;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (sio_ce) begin
            unique case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
                DATA: begin
                    if (bit_q != 3'd7) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end else begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Next frame starts straight after the stop bit, no idle gap
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        // A dropped write wins over a same-cycle clear
        if (we_i && full)   ovr_d = 1'b1;
        else if (clr_ovr_i) ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din_i;
    end

    assign txd_o   = txd_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign busy_o  = (state_q != IDLE);
    assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: frame shape, back-to-back, flow control,
// overrun, async reset mid-frame and FIFO pointer wrap.
module tb_uart_tx_ser;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       sio_ce = 1'b0;
    logic [7:0] din_i = '0;
    logic       we_i = 1'b0;
    logic       cts_i = 1'b0;
    logic       clr_ovr_i = 1'b0;
    logic       txd_o, full_o, empty_o, busy_o, ovr_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ce_div = 0;
    int ce_seen = 0;
    int busy_cnt = 0;
    logic busy_prev = 1'b0;
    logic empty_at_rise = 1'b0;
    logic txq [$];
    logic [8:0] rxb [$];

    uart_tx_ser #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .resetn(resetn), .sio_ce(sio_ce),
        .din_i(din_i), .we_i(we_i), .cts_i(cts_i), .clr_ovr_i(clr_ovr_i),
        .txd_o(txd_o), .full_o(full_o), .empty_o(empty_o),
        .busy_o(busy_o), .ovr_o(ovr_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ce_div = (ce_div + 1) % 4;
        sio_ce = (ce_div == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (sio_ce) begin
            txq.push_back(txd_o);
            ce_seen++;
        end
        if (busy_o) busy_cnt++;
        if (busy_o && !busy_prev) empty_at_rise = empty_o;
        busy_prev = busy_o;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        din_i = b;
        we_i = 1'b1;
        tick();
        we_i = 1'b0;
    endtask

    task automatic restart_log();
        txq.delete();
        busy_cnt = 0;
    endtask

    function automatic int zeros();
        int z = 0;
        foreach (txq[i]) if (txq[i] == 1'b0) z++;
        return z;
    endfunction

    function automatic int first_zero();
        foreach (txq[i]) if (txq[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic decode();
        int i = 0;
        logic [8:0] v;
        rxb.delete();
        while (i + 9 < txq.size()) begin
            if (txq[i] == 1'b0) begin
                for (int k = 1; k <= 9; k++) v[k-1] = txq[i+k];
                rxb.push_back(v);
                i += 10;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({txd_o, full_o, empty_o, busy_o, ovr_o} !== 5'b10100) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=10100",
                     {txd_o, full_o, empty_o, busy_o, ovr_o});
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        restart_log();
        run(20);
        n_cmp++;
        if (zeros() != 0 || busy_cnt != 0) begin
            n_bad++;
            $display("FAIL idle_ce zeros=%0d busy=%0d want 0/0", zeros(), busy_cnt);
        end
    endtask

    task automatic test_single();
        int z;
        logic [9:0] fr;
        restart_log();
        wr(8'hA5);
        n_cmp++;
        if (empty_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_empty_after_write got=%b want=0", empty_o);
        end
        run(100);
        z = first_zero();
        fr = '1;
        if (z >= 0 && z + 9 < txq.size())
            for (int k = 0; k < 10; k++) fr[k] = txq[z+k];
        n_cmp++;
        if (fr !== 10'b1_10100101_0) begin
            n_bad++;
            $display("FAIL single_frame got=%b want=%b", fr, 10'b1_10100101_0);
        end
        n_cmp++;
        if (busy_cnt != 40) begin
            n_bad++;
            $display("FAIL single_busy_clks got=%0d want=40", busy_cnt);
        end
        n_cmp++;
        if (empty_at_rise !== 1'b1) begin
            n_bad++;
            $display("FAIL single_empty_after_pop got=%b want=1", empty_at_rise);
        end
    endtask

    task automatic test_back_to_back();
        int z;
        int tail_zero;
        logic [19:0] fr;
        restart_log();
        wr(8'h01);
        wr(8'h80);
        run(120);
        z = first_zero();
        fr = '1;
        tail_zero = 0;
        if (z >= 0 && z + 19 < txq.size()) begin
            for (int k = 0; k < 20; k++) fr[k] = txq[z+k];
            for (int k = z + 20; k < txq.size(); k++)
                if (txq[k] == 1'b0) tail_zero++;
        end
        n_cmp++;
        if (fr !== 20'b1_10000000_0_1_00000001_0) begin
            n_bad++;
            $display("FAIL b2b_frames got=%b want=%b", fr, 20'b1_10000000_0_1_00000001_0);
        end
        n_cmp++;
        if (tail_zero != 0 || busy_o !== 1'b0 || busy_cnt != 80) begin
            n_bad++;
            $display("FAIL b2b_idle tailzeros=%0d busy=%b busyclks=%0d want 0/0/80",
                     tail_zero, busy_o, busy_cnt);
        end
    endtask

    task automatic test_cts_overrun();
        cts_i = 1'b1;
        restart_log();
        for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
        n_cmp++;
        if (full_o !== 1'b1 || ovr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL cts_full4 full=%b ovr=%b want 1/0", full_o, ovr_o);
        end
        wr(8'h14);
        n_cmp++;
        if (ovr_o !== 1'b1 || full_o !== 1'b1) begin
            n_bad++;
            $display("FAIL cts_ovr5 ovr=%b full=%b want 1/1", ovr_o, full_o);
        end
        run(40);
        n_cmp++;
        if (zeros() != 0 || busy_cnt != 0) begin
            n_bad++;
            $display("FAIL cts_hold zeros=%0d busy=%0d want 0/0", zeros(), busy_cnt);
        end
        restart_log();
        @(negedge clk);
        cts_i = 1'b0;
        run(180);
        decode();
        n_cmp++;
        if (rxb.size() != 4) begin
            n_bad++;
            $display("FAIL cts_nframes got=%0d want=4", rxb.size());
        end
        for (int i = 0; i < 4 && i < rxb.size(); i++) begin
            n_cmp++;
            if (rxb[i] !== 9'h110 + 9'(i)) begin
                n_bad++;
                $display("FAIL cts_byte%0d got=%h want=%h", i, rxb[i], 9'h110 + 9'(i));
            end
        end
        @(negedge clk);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        n_cmp++;
        if (ovr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL cts_clr_ovr got=%b want=0", ovr_o);
        end
    endtask

    task automatic test_pop_write_full();
        int guard = 0;
        cts_i = 1'b1;
        for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i));
        restart_log();
        while (ce_div != 3 && guard < 8) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (ce_div != 3) begin
            n_bad++;
            $display("FAIL popwr_sync ce_div=%0d want=3", ce_div);
        end
        @(negedge clk);
        cts_i = 1'b0;
        din_i = 8'h55;
        we_i = 1'b1;
        tick();
        n_cmp++;
        if ({ovr_o, full_o, busy_o, txd_o} !== 4'b1010) begin
            n_bad++;
            $display("FAIL popwr_edge ovr,full,busy,txd=%b want=1010",
                     {ovr_o, full_o, busy_o, txd_o});
        end
        @(negedge clk);
        din_i = 8'h56;
        tick();
        we_i = 1'b0;
        n_cmp++;
        if (full_o !== 1'b1) begin
            n_bad++;
            $display("FAIL popwr_refill full=%b want=1", full_o);
        end
        run(220);
        decode();
        n_cmp++;
        if (rxb.size() != 5) begin
            n_bad++;
            $display("FAIL popwr_nframes got=%0d want=5", rxb.size());
        end
        for (int i = 0; i < 5 && i < rxb.size(); i++) begin
            n_cmp++;
            if (rxb[i] !== ((i == 4) ? 9'h156 : 9'h120 + 9'(i))) begin
                n_bad++;
                $display("FAIL popwr_byte%0d got=%h", i, rxb[i]);
            end
        end
        @(negedge clk);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        int base;
        restart_log();
        wr(8'h00);
        while (!busy_o && guard < 20) begin
            tick();
            guard++;
        end
        base = ce_seen;
        for (int i = 0; i < 5; i++) wr(8'h33);
        guard = 0;
        while (ce_seen < base + 4 && guard < 40) begin
            tick();
            guard++;
        end
        n_cmp++;
        if ({busy_o, txd_o, ovr_o, full_o} !== 4'b1011) begin
            n_bad++;
            $display("FAIL rst_pre busy,txd,ovr,full=%b want=1011",
                     {busy_o, txd_o, ovr_o, full_o});
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({txd_o, empty_o, busy_o, ovr_o, full_o} !== 5'b11000) begin
            n_bad++;
            $display("FAIL rst_async txd,empty,busy,ovr,full=%b want=11000",
                     {txd_o, empty_o, busy_o, ovr_o, full_o});
        end
        @(negedge clk);
        resetn = 1'b1;
        busy_prev = 1'b0;
        restart_log();
        run(100);
        n_cmp++;
        if (zeros() != 0 || busy_cnt != 0 || empty_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_after zeros=%0d busy=%0d empty=%b want 0/0/1",
                     zeros(), busy_cnt, empty_o);
        end
    endtask

    task automatic test_wrap();
        restart_log();
        for (int b = 0; b < 6; b++) begin
            wr(8'(2 * b));
            wr(8'(2 * b + 1));
            run(100);
        end
        decode();
        n_cmp++;
        if (rxb.size() != 12) begin
            n_bad++;
            $display("FAIL wrap_nframes got=%0d want=12", rxb.size());
        end
        for (int i = 0; i < 12 && i < rxb.size(); i++) begin
            n_cmp++;
            if (rxb[i] !== 9'h100 + 9'(i)) begin
                n_bad++;
                $display("FAIL wrap_byte%0d got=%h want=%h", i, rxb[i], 9'h100 + 9'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cts_overrun();
        test_pop_write_full();
        test_reset_midframe();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
- Transmit stage of the memory-mapped UART.
- Buffers bytes written by the bus-side register logic in a small FIFO.
- Serializes each byte onto the TXD line as 8N1 frames, one bit per sio_ce tick from the baud-rate generator.
- Reports FIFO full/empty status and a sticky overrun flag back to the status register.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sio_ce  in  1  one-clk pulse per bit period, from the baud-rate generator
- din_i  in  8  byte to enqueue
- we_i  in  1  enqueue strobe, one clk per byte
- cts_i  in  1  flow control; 1 = hold off starting new frames
- clr_ovr_i  in  1  clears ovr_o
- txd_o  out  1  serial output, idle high, registered
- full_o  out  1  FIFO holds DEPTH bytes
- empty_o  out  1  FIFO holds 0 bytes
- busy_o  out  1  frame in progress, i.e. state not IDLE
- ovr_o  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert inside clk domain is the integrator's job):
  - txd_o=1, full_o=0, empty_o=1, busy_o=0, ovr_o=0
  - pointers=0, count=0, state=IDLE
- FIFO:
  - rd/wr pointers of AW bits that wrap modulo DEPTH; count of AW+1 bits.
  - full_o = (count==DEPTH); empty_o = (count==0). Both derive from registered count and update the clk after the event.
- Write:
  - we_i & ~full_o: store din_i at wr_ptr, wr_ptr+1, count+1.
  - we_i & full_o: drop the byte and set ovr_o on the next clk. This applies even if a pop occurs in the same clk; there is no write-through on pop.
- Pop: occurs only at frame start (see below). Head byte moves to shift register, rd_ptr+1, count-1.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- ovr_o:
  - clr_ovr_i clears it.
  - Set has priority over clear in the same clk.
- FSM, advancing only on clk edges where sio_ce=1:
  - IDLE: if ~empty_o & ~cts_i, pop, txd_o<=0, go to START. Otherwise txd_o stays 1.
  - START: txd_o<=shift[0], bit counter=0, go to DATA.
  - DATA: if bit counter<7, shift right, counter+1, txd_o<=next bit. At counter==7, txd_o<=1 and go to STOP.
  - STOP: if ~empty_o & ~cts_i, pop, txd_o<=0, go to START (back-to-back frames, no idle bit). Otherwise go to IDLE.
- Frame timing:
  - A frame occupies exactly 10 sio_ce periods: start bit, 8 data bits LSB first, stop bit.
  - txd_o changes only on the clk edge coincident with sio_ce.
- cts_i is sampled only at frame boundaries (IDLE or STOP with sio_ce). A frame in progress always completes.
- busy_o = (state != IDLE), registered with the state.
- Reset mid-frame: txd_o returns to 1 immediately (async), the frame is truncated, and FIFO contents are discarded.
- sio_ce pulses when state==IDLE and the FIFO is empty have no effect.

Test Plan:
1. sio_ce every 4 clk; write 0xA5 once.
   - txd_o over 10 consecutive sio_ce periods = 0,1,0,1,0,0,1,0,1,1.
   - busy_o high for 40 clk.
   - empty_o=1 one clk after the pop.
2. Write 0x01, 0x80 back-to-back with cts_i=0.
   - Two frames with no idle gap: 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1.
   - Then idle high, busy_o=0.
3. cts_i=1; write DEPTH+1 bytes 0x10..0x14.
   - full_o=1 after the 4th write; 5th byte dropped; ovr_o=1.
   - txd_o stays 1.
   - Release cts_i: bytes 0x10..0x13 are sent in order.
   - clr_ovr_i pulse clears ovr_o.
4. FIFO full, pop at frame start, with we_i in the same clk.
   - Write dropped; ovr_o=1; count goes DEPTH→DEPTH-1.
   - Next clk write accepted; full_o=1 again.
5. Assert resetn=0 at DATA bit 3 of a frame.
   - txd_o=1 the same cycle without a clk edge.
   - empty_o=1, busy_o=0, ovr_o=0.
   - After release, no further frame is emitted.
6. Pointer wrap: 3×DEPTH bytes written in bursts of 2, each burst drained.
   - All bytes (0x00..0x0B) emitted in order with no corruption across wrap.
